// File: rtl/adc_capture_sched_pkg.sv
// rtl/adc_capture_sched_pkg.sv - shared state encoding, control-word layout and defaults for adc_capture_sched
package adc_capture_sched_pkg;

    // FSM state encoding; values are visible on state_o for debug.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_HDR0  = 3'd2;
    localparam logic [2:0] ST_HDR1  = 3'd3;
    localparam logic [2:0] ST_CAPT  = 3'd4;
    localparam logic [2:0] ST_TRAIL = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // Bit positions inside the 32-bit control word from the fiber RX path.
    localparam int CFG_ENABLE_BIT  = 0;
    localparam int CFG_CONT_BIT    = 1;
    localparam int CFG_FORCE_BIT   = 2;
    localparam int CFG_CLR_OVF_BIT = 3;
    localparam int CFG_THR_LSB     = 8;
    localparam int CFG_LEN_LSB     = 16;

    // First word of every frame unless the top overrides it.
    localparam logic [15:0] HDR_WORD_DEFAULT = 16'hA55A;

    typedef struct packed {
        logic        enable;
        logic        continuous;
        logic        force_trig;
        logic        clr_ovf;
        logic [7:0]  threshold;
        logic [15:0] length;
    } cfg_t;

    function automatic cfg_t decode_cfg(input logic [31:0] w);
        cfg_t c;
        c.enable     = w[CFG_ENABLE_BIT];
        c.continuous = w[CFG_CONT_BIT];
        c.force_trig = w[CFG_FORCE_BIT];
        c.clr_ovf    = w[CFG_CLR_OVF_BIT];
        c.threshold  = w[CFG_THR_LSB +: 8];
        c.length     = w[CFG_LEN_LSB +: 16];
        return c;
    endfunction

endpackage

// File: rtl/adc_capture_sched_trig.sv
// rtl/adc_capture_sched_trig.sv - adc_trig_detect: rising threshold-crossing and forced trigger detector
module adc_trig_detect (
    input  logic       clk,
    input  logic       rst,
    input  logic       armed,
    input  logic       smp_valid,
    input  logic [7:0] smp_a,
    input  logic [7:0] threshold,
    input  logic       force_set,
    input  logic       clr_pending,
    input  logic       reload_prev,
    output logic       trig
);

    logic [7:0] prev_a;
    logic       force_pending;
    logic       crossing;

    assign crossing = (prev_a < threshold) && (smp_a >= threshold);
    assign trig     = armed && smp_valid && (force_pending || crossing);

    // Track the previous data_a while armed; reload to threshold at frame end so a fresh crossing is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_a <= 8'd0;
        end else if (reload_prev) begin
            prev_a <= threshold;
        end else if (armed && smp_valid) begin
            prev_a <= smp_a;
        end
    end

    // Hold a forced trigger request until it fires on the next armed sample or the capture is aborted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            force_pending <= 1'b0;
        end else if (trig || clr_pending) begin
            force_pending <= 1'b0;
        end else if (force_set) begin
            force_pending <= 1'b1;
        end
    end

endmodule

// File: rtl/adc_capture_sched.sv
// rtl/adc_capture_sched.sv - framed ADC burst capture into the fiber TX FIFO; FRAME_CKSUM_EN adds a sum trailer
module adc_capture_sched
    import adc_capture_sched_pkg::*;
#(
    parameter logic [15:0] HDR_WORD = HDR_WORD_DEFAULT,
    parameter int          LEN_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    input  logic [31:0] cfg_word,
    input  logic        smp_valid,
    input  logic [15:0] smp_data,
    input  logic        fifo_almost_full,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_wr_data,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        ovf,
    output logic [2:0]  state_o
);

    cfg_t             cfg;
    logic             cfg_en;
    logic             cfg_abort;
    logic             cfg_unused;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             wr_en_nxt;
    logic [15:0]      wr_data_nxt;
    logic             smp_take;
    logic             smp_write;
    logic             drop;
    logic             load_remaining;

    logic [7:0]       thr_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] remaining;
    logic             cont_q;
    logic             trig;

`ifdef FRAME_CKSUM_EN
    logic [15:0]      cksum;
`endif

    assign cfg        = decode_cfg(cfg_word);
    assign cfg_en     = cfg_valid && cfg.enable;
    assign cfg_abort  = cfg_valid && !cfg.enable;
    assign cfg_unused = ^cfg_word[7:4];
    assign state_o    = state;

    adc_trig_detect u_trig (
        .clk         (clk),
        .rst         (rst),
        .armed       (state == ST_ARMED),
        .smp_valid   (smp_valid),
        .smp_a       (smp_data[15:8]),
        .threshold   (thr_q),
        .force_set   (cfg_en && cfg.force_trig && ((state == ST_IDLE) || (state == ST_ARMED))),
        .clr_pending (cfg_abort),
        .reload_prev (state == ST_DONE),
        .trig        (trig)
    );

    // Next state and the write to issue this cycle; an abort suppresses everything.
    always_comb begin
        state_nxt      = state;
        wr_en_nxt      = 1'b0;
        wr_data_nxt    = HDR_WORD;
        smp_take       = 1'b0;
        smp_write      = 1'b0;
        drop           = 1'b0;
        load_remaining = 1'b0;
        if (cfg_abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_en) begin
                        state_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        state_nxt = ST_HDR0;
                    end
                end
                ST_HDR0: begin
                    if (!fifo_almost_full) begin
                        wr_en_nxt   = 1'b1;
                        wr_data_nxt = HDR_WORD;
                        state_nxt   = ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (!fifo_almost_full) begin
                        wr_en_nxt      = 1'b1;
                        wr_data_nxt    = frame_cnt;
                        load_remaining = 1'b1;
                        state_nxt      = ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    if (smp_valid) begin
                        smp_take = 1'b1;
                        if (!fifo_almost_full) begin
                            smp_write   = 1'b1;
                            wr_en_nxt   = 1'b1;
                            wr_data_nxt = smp_data;
                        end else begin
                            drop = 1'b1;
                        end
                        if (remaining == LEN_W'(1)) begin
`ifdef FRAME_CKSUM_EN
                            state_nxt = ST_TRAIL;
`else
                            state_nxt = ST_DONE;
`endif
                        end
                    end
                end
                ST_TRAIL: begin
`ifdef FRAME_CKSUM_EN
                    if (!fifo_almost_full) begin
                        wr_en_nxt   = 1'b1;
                        wr_data_nxt = cksum;
                        state_nxt   = ST_DONE;
                    end
`else
                    state_nxt = ST_IDLE;
`endif
                end
                ST_DONE: begin
                    state_nxt = cont_q ? ST_ARMED : ST_IDLE;
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register plus the registered FIFO write port and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= 16'd0;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != ST_IDLE);
            fifo_wr_en <= wr_en_nxt;
            if (wr_en_nxt) begin
                fifo_wr_data <= wr_data_nxt;
            end
        end
    end

    // Latch threshold, length and mode only when starting from IDLE; a zero length means one sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_q  <= 8'd0;
            len_q  <= '0;
            cont_q <= 1'b0;
        end else if ((state == ST_IDLE) && cfg_en) begin
            thr_q  <= cfg.threshold;
            len_q  <= (cfg.length == 16'd0) ? LEN_W'(1) : LEN_W'(cfg.length);
            cont_q <= cfg.continuous;
        end
    end

    // Sample countdown; counts dropped samples too so the frame stays time-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
        end else if (load_remaining) begin
            remaining <= len_q;
        end else if (smp_take) begin
            remaining <= remaining - LEN_W'(1);
        end
    end

    // Completed-frame counter, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 16'd0;
        end else if (state == ST_DONE) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (cfg_valid && cfg.clr_ovf) begin
            ovf <= 1'b0;
        end
    end

`ifdef FRAME_CKSUM_EN
    // Modulo-2^16 sum of the sample words actually written in this frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cksum <= 16'd0;
        end else if (state == ST_HDR0) begin
            cksum <= 16'd0;
        end else if (smp_write) begin
            cksum <= cksum + smp_data;
        end
    end
`endif

endmodule

// File: tb/tb_adc_capture_sched.sv
// tb/tb_adc_capture_sched.sv - directed self-checking bench for adc_capture_sched
module tb_adc_capture_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [31:0] cfg_word;
    logic        smp_valid;
    logic [15:0] smp_data;
    logic        fifo_almost_full;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        ovf;
    logic [2:0]  state_o;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] wq[$];
    logic [15:0] exp_q[$];
    logic [7:0]  a;
    logic [7:0]  t4[7];
    logic [15:0] t6[8];

    always #5 clk = ~clk;

    adc_capture_sched dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_valid        (cfg_valid),
        .cfg_word         (cfg_word),
        .smp_valid        (smp_valid),
        .smp_data         (smp_data),
        .fifo_almost_full (fifo_almost_full),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_wr_data     (fifo_wr_data),
        .busy             (busy),
        .frame_cnt        (frame_cnt),
        .ovf              (ovf),
        .state_o          (state_o)
    );

    always @(negedge clk) begin
        if (!rst && fifo_wr_en) wq.push_back(fifo_wr_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_writes(input string tag);
        chk($sformatf("%s_count", tag), 32'(wq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), (i < wq.size()) ? 32'(wq[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
        end
        wq.delete();
    endtask

    task automatic drive(input logic cv, input logic [31:0] cw, input logic sv, input logic [15:0] sd, input logic af);
        cfg_valid        = cv;
        cfg_word         = cw;
        smp_valid        = sv;
        smp_data         = sd;
        fifo_almost_full = af;
        @(negedge clk);
        #1;
        cfg_valid        = 1'b0;
        smp_valid        = 1'b0;
        fifo_almost_full = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_word = 32'd0;
        smp_valid = 1'b0; smp_data = 16'd0; fifo_almost_full = 1'b0;
        t4 = '{8'h70, 8'h90, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        t6 = '{16'h7000, 16'h9000, 16'h9100, 16'h9200, 16'h8000, 16'h9001, 16'h0000, 16'h0000};
        @(negedge clk); #1;
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 16'd0, 1'b0);

        // one-shot frame, len 4, threshold 0x80, ramp crossing at 0x90
        drive(1'b1, 32'h0004_8001, 1'b0, 16'd0, 1'b0);
        chk("t2_armed", 32'(state_o), 32'd1);
        chk("t2_busy_armed", 32'(busy), 32'd1);
        for (int i = 0; i < 9; i++) begin
            a = (i == 0) ? 8'h70 : (i == 1) ? 8'h90 : 8'h8F + 8'(i);
            drive(1'b0, 32'd0, 1'b1, {a, 8'(i)}, 1'b0);
            if (i == 1) chk("t2_hdr0_after_trig", 32'(state_o), 32'd2);
        end
        exp_q = '{16'hA55A, 16'h0000, 16'h9304, 16'h9405, 16'h9506, 16'h9607};
        chk_writes("t2_wr");
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t2_idle", 32'(state_o), 32'd0);
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_ovf", 32'(ovf), 32'd0);

        // header stalled 2 cycles, one sample dropped
        drive(1'b1, 32'h0004_8001, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            a = (i == 0) ? 8'h70 : (i == 1) ? 8'h90 : 8'h8F + 8'(i);
            drive(1'b0, 32'd0, 1'b1, {a, 8'(i)}, (i == 2) || (i == 3) || (i == 7));
            if (i == 3) begin
                chk("t3_hdr_stall_state", 32'(state_o), 32'd2);
                chk("t3_hdr_stall_wr", 32'(fifo_wr_en), 32'd0);
                chk("t3_hdr_stall_cnt", 32'(wq.size()), 32'd0);
            end
            if (i == 4) chk("t3_hdr_written_state", 32'(state_o), 32'd3);
            if (i == 7) chk("t3_ovf_on_drop", 32'(ovf), 32'd1);
        end
        exp_q = '{16'hA55A, 16'h0001, 16'h9506, 16'h9708, 16'h9809};
        chk_writes("t3_wr");
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("t3_ovf_sticky", 32'(ovf), 32'd1);
        chk("t3_idle", 32'(state_o), 32'd0);
        drive(1'b1, 32'h0000_0008, 1'b0, 16'd0, 1'b0);
        chk("t3_ovf_cleared", 32'(ovf), 32'd0);

        // asynchronous reset in the middle of CAPT
        drive(1'b1, 32'h0004_8001, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a = (i == 0) ? 8'h70 : (i == 1) ? 8'h90 : 8'h8F + 8'(i);
            drive(1'b0, 32'd0, 1'b1, {a, 8'(i)}, 1'b0);
        end
        chk("t1_in_capt", 32'(state_o), 32'd4);
        chk("t1_wr_before_rst", 32'(fifo_wr_en), 32'd1);
        exp_q = '{16'hA55A, 16'h0002, 16'h9304};
        chk_writes("t1_wr");
        #2 rst = 1'b1;
        #1;
        chk("t1_rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("t1_rst_wr_data", 32'(fifo_wr_data), 32'd0);
        chk("t1_rst_state", 32'(state_o), 32'd0);
        chk("t1_rst_busy", 32'(busy), 32'd0);
        chk("t1_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t1_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        wq.delete();

        // continuous mode, three crossings, then frame_cnt wrap
        drive(1'b1, 32'h0002_8003, 1'b0, 16'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 7; i++) drive(1'b0, 32'd0, 1'b1, {t4[i], 8'(k)}, 1'b0);
            exp_q = '{16'hA55A, 16'(k), {8'hA3, 8'(k)}, {8'hA4, 8'(k)}};
            chk_writes($sformatf("t4_frame%0d", k));
            chk($sformatf("t4_cnt%0d", k), 32'(frame_cnt), 32'(k + 1));
            chk($sformatf("t4_rearmed%0d", k), 32'(state_o), 32'd1);
        end
        force dut.frame_cnt = 16'hFFFF;
        @(negedge clk); #1;
        release dut.frame_cnt;
        @(negedge clk); #1;
        chk("t4_preload", 32'(frame_cnt), 32'hFFFF);
        for (int i = 0; i < 7; i++) drive(1'b0, 32'd0, 1'b1, {t4[i], 8'h03}, 1'b0);
        exp_q = '{16'hA55A, 16'hFFFF, 16'hA303, 16'hA403};
        chk_writes("t4_wrap_wr");
        chk("t4_wrap_cnt", 32'(frame_cnt), 32'd0);
        drive(1'b1, 32'h0000_0000, 1'b0, 16'd0, 1'b0);
        chk("t4_abort_idle", 32'(state_o), 32'd0);

        // forced trigger on flat data, then abort mid-capture
        drive(1'b1, 32'h0002_FF05, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 6; i++) drive(1'b0, 32'd0, 1'b1, 16'h1010, 1'b0);
        exp_q = '{16'hA55A, 16'h0000, 16'h1010, 16'h1010};
        chk_writes("t5_force_wr");
        chk("t5_force_cnt", 32'(frame_cnt), 32'd1);
        chk("t5_force_idle", 32'(state_o), 32'd0);
        drive(1'b1, 32'h0002_FF05, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'd0, 1'b1, 16'h1010, 1'b0);
        chk("t5_capt_writing", 32'(fifo_wr_en), 32'd1);
        drive(1'b1, 32'h0000_0000, 1'b1, 16'h1010, 1'b0);
        chk("t5_abort_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("t5_abort_state", 32'(state_o), 32'd0);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'd0, 1'b1, 16'h1010, 1'b0);
        exp_q = '{16'hA55A, 16'h0001, 16'h1010};
        chk_writes("t5_abort_wr");
        chk("t5_abort_cnt", 32'(frame_cnt), 32'd1);

        // len 2 frame; the trailer carries 0x8000 + 0x9001 when the checksum is built in
        drive(1'b1, 32'h0002_8001, 1'b0, 16'd0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 32'd0, 1'b1, t6[i], 1'b0);
`ifdef FRAME_CKSUM_EN
        exp_q = '{16'hA55A, 16'h0001, 16'h8000, 16'h9001, 16'h1001};
`else
        exp_q = '{16'hA55A, 16'h0001, 16'h8000, 16'h9001};
`endif
        chk_writes("t6_wr");
        chk("t6_cnt", 32'(frame_cnt), 32'd2);
        chk("t6_idle", 32'(state_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
